sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-port arbiter that shares the single board SRAM interface between the CPU path and a second requester, the program loader/debug reader ("ldr").
- Sits between the cpu/io-bridge memory signals and the physical sram_* pins in the slc3 top level.
- Serialises accesses, latches each request, waits the fixed SRAM read latency, and returns data with a one-cycle ready pulse.
- Uses round-robin fairness so neither requester starves.

Parameters:
- ADDR_W, 16, address width for both requesters and SRAM.
- DATA_W, 16, data width.
- RD_LATENCY, 2, cycles sram_mem_ena is held before sram_rdata is sampled (range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_ena  in  1  CPU request; held high until cpu_ready.
- cpu_wr_ena  in  1  CPU write (1) / read (0); sampled with the request.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  last CPU read result.
- cpu_ready  out  1  one-cycle completion pulse.
- ldr_mem_ena, ldr_wr_ena, ldr_addr, ldr_wdata, ldr_rdata, ldr_ready  same as cpu_* for the loader port.
- sram_mem_ena  out  1  SRAM enable.
- sram_wr_ena  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data.
- busy_o  out  1  high while not IDLE.
- grant_o  out  1  owner of the current or last transaction (0 = cpu, 1 = ldr).

Behaviour:
- Reset values:
  - State IDLE.
  - All sram_* outputs 0.
  - cpu_rdata and ldr_rdata 0.
  - Both ready outputs 0.
  - busy_o 0.
  - last_grant 1, so the CPU wins the first tie.
  - grant_o 0.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one *_mem_ena high: grant that port.
  - Both high: grant the port that is not last_grant.
  - On grant: latch the winner's addr, wdata and wr_ena into registers, load counter with RD_LATENCY-1, go to ACCESS.
- ACCESS:
  - sram_* outputs are driven only from the latched registers; sram_mem_ena = 1.
  - Counter decrements each cycle; at 0, go to DONE.
  - Duration is exactly RD_LATENCY cycles.
- DONE:
  - sram_mem_ena = 0 and sram_wr_ena = 0.
  - If the latched op was a read: the granted port's rdata register takes sram_rdata (sampled at the clock edge entering DONE).
  - The granted port's ready = 1 for this cycle only.
  - last_grant takes the granted port; go to IDLE.
- Latency: request seen in IDLE at cycle 0; ready and valid rdata at cycle RD_LATENCY+1. Default is 3 cycles; a cycle-0 request sees ready in cycle 3.
- Throughput: one access per RD_LATENCY+2 cycles.
- Requester rule: deassert *_mem_ena on the edge ending the ready cycle. If it is still high in the following IDLE cycle, that is a new request (back-to-back).
- Request changes mid-transaction: addr, wdata and wr_ena changes during ACCESS/DONE are ignored because values are latched. Dropping *_mem_ena mid-transaction does not abort; ready still pulses.
- Losing port: waits with no side effects and is granted in the next IDLE.
- Writes: rdata for that port is unchanged.
- rdata hold: each port's rdata holds until its next completed read.
- Reset mid-ACCESS:
  - State returns to IDLE and sram_mem_ena drops on the next edge.
  - No ready pulse; rdata cleared to 0.
- sram_addr and sram_wdata hold their last latched values in IDLE/DONE (no X, no toggling).
- grant_o updates at grant time; busy_o = (state != IDLE).

Decomposition:
- arb_pkg:
  - state enum {IDLE, ACCESS, DONE}.
  - Port index constants PORT_CPU = 0, PORT_LDR = 1.
  - Counter width localparam (4 bits).
- Sub-module rr_pick2: combinational 2-way round-robin selector with inputs req[1:0] and last; outputs valid and winner. It is unit-testable on its own.
- The FSM, latches and counter stay in sram_arbiter.

Test Plan:
- CPU read, RD_LATENCY=2, SRAM model returns x1234 at addr x0040: cpu_mem_ena at cycle 0 -> sram_mem_ena high cycles 1–2 with sram_addr=x0040; cpu_ready pulse in cycle 3; cpu_rdata=x1234; ldr_ready stays 0.
- Loader write x3000 <= xBEEF -> sram_wr_ena=1 and sram_wdata=xBEEF for 2 cycles; ldr_ready at cycle 3; a following CPU read of x3000 returns xBEEF; ldr_rdata unchanged.
- Both ports request continuously from reset -> grants alternate CPU, LDR, CPU, LDR; each ready pulse occurs every 4 cycles; neither port waits more than one transaction.
- CPU holds cpu_mem_ena high and changes cpu_addr x0001 -> x0002 during ACCESS -> first access uses x0001, second back-to-back access uses x0002; no idle gap beyond the IDLE cycle.
- Reset asserted in the 2nd ACCESS cycle of a CPU read -> next cycle: sram_mem_ena=0, busy_o=0, no cpu_ready, cpu_rdata=0; a subsequent request completes normally.
- RD_LATENCY=1 build: single CPU read -> ready at cycle 2; sram_mem_ena high exactly 1 cycle.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared types and constants for the two-port SRAM arbiter.
//   state_t  : arbiter FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   PORT_CPU : requester index of the CPU path
//   PORT_LDR : requester index of the program loader / debug reader
//   CNT_W    : width of the access-latency down-counter (RD_LATENCY <= 15)
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// One memory-request bundle. Used for both requester ports (cpu, ldr) and for
// the physical SRAM pins.
//
// Handshake: the master raises mem_ena together with wr_ena/addr/wdata and
// keeps mem_ena high until it sees ready (a one-cycle pulse). Any mem_ena
// still high in the cycle after ready is a new request. For reads, rdata is
// valid in the ready cycle and holds until the port's next completed read.
//
// Signals:
//   mem_ena  request / SRAM enable
//   wr_ena   1 = write, 0 = read
//   addr     address
//   wdata    write data
//   rdata    read data
//   ready    one-cycle completion pulse (not used on the SRAM side)
//
// Modports:
//   master      : requester side (drives request, receives rdata/ready)
//   slave       : arbiter side of a requester port
//   sram_master : arbiter side of the SRAM pins (no ready from the SRAM)
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_ena;
  logic              wr_ena;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output mem_ena, wr_ena, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  mem_ena, wr_ena, addr, wdata,
    output rdata, ready
  );

  modport sram_master (
    output mem_ena, wr_ena, addr, wdata,
    input  rdata
  );

endinterface

// File: rtl/sram_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational 2-way round-robin selector.
//   req_i[1:0] : request lines, indexed by PORT_CPU / PORT_LDR
//   last_i     : port that owned the previous transaction
//   valid_o    : at least one request present
//   winner_o   : selected port (only meaningful when valid_o = 1)
// On a tie the port that did not go last wins, so neither side starves.
// -----------------------------------------------------------------------------
module rr_pick2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = PORT_CPU;
    if (req_i[PORT_LDR] && req_i[PORT_CPU]) begin
      winner_o = ~last_i;
    end else if (req_i[PORT_LDR]) begin
      winner_o = PORT_LDR;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one SRAM between the CPU path and the loader/debug reader. Each
// request is latched in IDLE, the SRAM is enabled for exactly RD_LATENCY
// cycles, then a DONE cycle returns read data with a one-cycle ready pulse.
// One access every RD_LATENCY+2 cycles.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   cpu          requester port 0 (slave side)
//   ldr          requester port 1 (slave side)
//   sram         physical SRAM pins (master side)
//   busy_o       high while the FSM is not IDLE
//   grant_o      owner of the current or last transaction (0 cpu, 1 ldr)
//   dbg_state_o  current FSM state
// -----------------------------------------------------------------------------
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_arbiter_if.slave            cpu,
  sram_arbiter_if.slave            ldr,
  sram_arbiter_if.sram_master      sram,
  output logic                     busy_o,
  output logic                     grant_o,
  output state_t                   dbg_state_o
);

  // ACCESS lasts RD_LATENCY cycles: the counter is loaded with RD_LATENCY-1
  // and the state moves on when it is already 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 u_pick (
    .req_i    ({ldr.mem_ena, cpu.mem_ena}),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  // State and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= PORT_CPU;
      last_q      <= PORT_LDR;   // CPU wins the first tie after reset
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          if (pick_winner == PORT_LDR) begin
            addr_d  = ldr.addr;
            wdata_d = ldr.wdata;
            wr_d    = ldr.wr_ena;
          end else begin
            addr_d  = cpu.addr;
            wdata_d = cpu.wdata;
            wr_d    = cpu.wr_ena;
          end
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          // Read data is captured on the edge that enters DONE, so it is
          // already visible in the ready cycle.
          if (!wr_q) begin
            if (grant_q == PORT_LDR) begin
              ldr_rdata_d = sram.rdata;
            end else begin
              cpu_rdata_d = sram.rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pins come only from the latched registers, so requester changes
  // during a transaction never reach the SRAM. addr/wdata hold between
  // transactions instead of toggling.
  assign sram.mem_ena = (state_q == ACCESS);
  assign sram.wr_ena  = (state_q == ACCESS) && wr_q;
  assign sram.addr    = addr_q;
  assign sram.wdata   = wdata_q;

  assign cpu.rdata = cpu_rdata_q;
  assign ldr.rdata = ldr_rdata_q;
  assign cpu.ready = (state_q == DONE) && (grant_q == PORT_CPU);
  assign ldr.ready = (state_q == DONE) && (grant_q == PORT_LDR);

  assign busy_o      = (state_q != IDLE);
  assign grant_o     = grant_q;
  assign dbg_state_o = state_q;

endmodule
